// File: rtl/sram_responder.sv
// On-chip stand-in for the external 16-bit SRAM behind the active-low strobe bus.
// Answers timed read/write strobe sequences, honours byte lanes, and flags bus misuse.
module sram_responder #(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [19:0]       ADDR,
    input  logic [15:0]       Data_to_SRAM,
    input  logic              Mem_CE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic              Init_we,
    input  logic [ADDR_W-1:0] Init_addr,
    input  logic [15:0]       Init_data,
    output logic [15:0]       Data_from_SRAM,
    output logic              Rd_valid,
    output logic              Wr_done,
    output logic              Proto_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] RD_LAT_C = 4'(READ_LAT);
    localparam logic [3:0] WR_LAT_C = 4'(WRITE_LAT);

    typedef enum logic [1:0] {IDLE, READ, WRITE, WHOLD} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic               wr_done_reg;
    logic               proto_err_reg;
    logic               commit;
    logic               commit_en;
    logic               proto_set;

    logic [ADDR_W-1:0]  addr_w;
    logic               ce_act;
    logic               wr_act;
    logic               rd_act;
    logic               addr_same;
    logic [15:0]        rd_word;

    // Upper MAR bits are deliberately not decoded, so the image aliases.
    assign addr_w = ADDR[ADDR_W-1:0];
    generate
        if (ADDR_W < 20) begin : g_alias
            logic addr_unused;
            assign addr_unused = ^ADDR[19:ADDR_W];
        end
    endgenerate

    assign ce_act    = !Mem_CE;
    assign wr_act    = ce_act && !Mem_WE;
    assign rd_act    = ce_act && !Mem_OE && Mem_WE;
    assign addr_same = (addr_w == addr_reg);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            addr_reg      <= '0;
            wr_done_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            wr_done_reg   <= commit_en;
            proto_err_reg <= proto_err_reg | proto_set;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        commit     = 1'b0;
        proto_set  = (ce_act && !Mem_OE && !Mem_WE)
                   || (wr_act && Mem_UB && Mem_LB)
                   || (state_reg == WRITE && wr_act && !addr_same);
        case (state_reg)
            IDLE: begin
                if (wr_act) begin
                    addr_next = addr_w;
                    cnt_next  = 4'd1;
                    if (WR_LAT_C == 4'd1) begin
                        commit     = 1'b1;
                        state_next = WHOLD;
                    end else begin
                        state_next = WRITE;
                    end
                end else if (rd_act) begin
                    addr_next  = addr_w;
                    cnt_next   = 4'd1;
                    state_next = READ;
                end
            end
            READ: begin
                if (!rd_act) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (!addr_same) begin
                    addr_next = addr_w;
                    cnt_next  = 4'd1;
                end else if (cnt_reg < RD_LAT_C) begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            WRITE: begin
                if (!wr_act) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (!addr_same) begin
                    addr_next = addr_w;
                    cnt_next  = 4'd1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg + 4'd1 == WR_LAT_C) begin
                        commit     = 1'b1;
                        state_next = WHOLD;
                    end
                end
            end
            WHOLD: begin
                // One commit per WE assertion; the master must release WE to write again.
                if (!wr_act) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // A reset landing on the commit edge discards the pending write.
    assign commit_en = commit && !Reset;

    // One byte-wide array per lane; the preload port is listed last so it wins a same-address collision.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH-1];
            logic [7:0] rd_reg;
            logic       lane_en;

            assign lane_en = (gi == 0) ? !Mem_LB : !Mem_UB;

            always_ff @(posedge Clk) begin
                if (commit_en && lane_en) begin
                    mem[addr_w] <= Data_to_SRAM[gi*8 +: 8];
                end
                if (Init_we) begin
                    mem[Init_addr] <= Init_data[gi*8 +: 8];
                end
                rd_reg <= mem[addr_w];
            end
        end
    endgenerate

    assign rd_word = {g_lane[1].rd_reg, g_lane[0].rd_reg};

    assign Rd_valid = (state_reg == READ) && rd_act && addr_same
                      && (cnt_reg >= RD_LAT_C - 4'd1);

    always_comb begin
        Data_from_SRAM = 16'h0000;
        if (Rd_valid) begin
            Data_from_SRAM[15:8] = Mem_UB ? 8'h00 : rd_word[15:8];
            Data_from_SRAM[7:0]  = Mem_LB ? 8'h00 : rd_word[7:0];
        end
    end

    assign Wr_done   = wr_done_reg;
    assign Proto_err = proto_err_reg;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: stimulus queues timed expectations,
// a negedge monitor matches every Rd_valid / Wr_done against them.
module tb_sram_responder;

    localparam int ADDR_W    = 10;
    localparam int READ_LAT  = 2;
    localparam int WRITE_LAT = 2;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [19:0]       ADDR;
    logic [15:0]       Data_to_SRAM;
    logic              Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic              Init_we;
    logic [ADDR_W-1:0] Init_addr;
    logic [15:0]       Init_data;
    logic [15:0]       Data_from_SRAM;
    logic              Rd_valid;
    logic              Wr_done;
    logic              Proto_err;

    sram_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)) dut (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Init_we(Init_we), .Init_addr(Init_addr), .Init_data(Init_data),
        .Data_from_SRAM(Data_from_SRAM), .Rd_valid(Rd_valid), .Wr_done(Wr_done),
        .Proto_err(Proto_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          is_rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   started = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end else begin
            $display("[TB] ok %s cycle %0d: %h", name, cyc, act);
        end
    endtask

    always @(negedge Clk) begin
        if (started && !Reset) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_%s due cycle %0d: got none expected one", q[0].is_rd ? "read" : "wrdone", q[0].cyc);
                void'(q.pop_front());
            end
            if (!Rd_valid) check("gated_data", Data_from_SRAM, 16'h0000);
            if (Rd_valid || Wr_done) begin
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output cycle %0d: got Rd_valid=%b Wr_done=%b expected none", cyc, Rd_valid, Wr_done);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.is_rd) begin
                        check("rd_valid", {15'd0, Rd_valid}, 16'd1);
                        check("rd_data", Data_from_SRAM, e.data);
                    end else begin
                        check("wr_done", {15'd0, Wr_done}, 16'd1);
                        check("wr_no_rd", {15'd0, Rd_valid}, 16'd0);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        Mem_UB = 1'b0; Mem_LB = 1'b0; Init_we = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic init_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        Init_we = 1'b1; Init_addr = a; Init_data = d;
        tick();
        Init_we = 1'b0;
    endtask

    task automatic bus_read(input logic [19:0] a, input logic ub, input logic lb,
                            input int n, input logic [15:0] exp_d);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
        Mem_UB = ub; Mem_LB = lb; ADDR = a;
        for (int i = 0; i < n; i++) begin
            if (i >= READ_LAT - 1) q.push_back('{1'b1, exp_d, cyc});
            tick();
        end
        idle();
        tick();
    endtask

    task automatic bus_write(input logic [19:0] a, input logic [15:0] d, input logic ub,
                             input logic lb, input logic oe, input int n);
        Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = oe;
        Mem_UB = ub; Mem_LB = lb; ADDR = a; Data_to_SRAM = d;
        if (n >= WRITE_LAT) q.push_back('{1'b0, 16'h0000, cyc + WRITE_LAT});
        for (int i = 0; i < n; i++) tick();
        idle();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        ADDR = 20'h0; Data_to_SRAM = 16'h0; Init_addr = '0; Init_data = 16'h0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        started = 1'b1;
        check("reset_rd_valid", {15'd0, Rd_valid}, 16'd0);
        check("reset_wr_done", {15'd0, Wr_done}, 16'd0);
        check("reset_proto", {15'd0, Proto_err}, 16'd0);
        check("reset_data", Data_from_SRAM, 16'h0000);

        // Basic read latency
        init_wr(10'h003, 16'h1234);
        bus_read(20'h00003, 1'b0, 1'b0, 2, 16'h1234);

        // Full write, read back; long WE gives one pulse
        bus_write(20'h00010, 16'hABCD, 1'b0, 1'b0, 1'b1, 2);
        bus_read(20'h00010, 1'b0, 1'b0, 2, 16'hABCD);
        bus_write(20'h00011, 16'h5555, 1'b0, 1'b0, 1'b1, 5);
        bus_read(20'h00011, 1'b0, 1'b0, 3, 16'h5555);

        // Byte lanes
        init_wr(10'h020, 16'h1111);
        bus_write(20'h00020, 16'hFF00, 1'b0, 1'b1, 1'b1, 2);
        bus_read(20'h00020, 1'b0, 1'b0, 2, 16'hFF11);
        bus_read(20'h00020, 1'b1, 1'b0, 2, 16'h0011);
        check("lane_no_proto", {15'd0, Proto_err}, 16'd0);

        // Aliasing on undecoded upper bits
        bus_read(20'h00403, 1'b0, 1'b0, 2, 16'h1234);

        // Address change during a read restarts the latency
        init_wr(10'h030, 16'h3030);
        init_wr(10'h031, 16'h3131);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; ADDR = 20'h00030;
        tick();
        ADDR = 20'h00031;
        tick();
        q.push_back('{1'b1, 16'h3131, cyc});
        tick();
        idle();
        tick();
        check("rd_addr_chg_no_proto", {15'd0, Proto_err}, 16'd0);

        // Address change during a write: error, 0x030 untouched
        Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 20'h00030; Data_to_SRAM = 16'hDEAD;
        tick();
        ADDR = 20'h00031;
        tick();
        idle();
        check("wr_addr_chg_proto", {15'd0, Proto_err}, 16'd1);
        tick();
        bus_read(20'h00030, 1'b0, 1'b0, 2, 16'h3030);
        bus_read(20'h00031, 1'b0, 1'b0, 2, 16'h3131);
        do_reset();
        check("proto_cleared", {15'd0, Proto_err}, 16'd0);

        // OE and WE together: write wins, read gated, error sticky
        bus_write(20'h00040, 16'h4444, 1'b0, 1'b0, 1'b0, 2);
        check("oe_we_proto", {15'd0, Proto_err}, 16'd1);
        bus_read(20'h00040, 1'b0, 1'b0, 2, 16'h4444);
        check("proto_sticky", {15'd0, Proto_err}, 16'd1);
        do_reset();
        check("proto_reset", {15'd0, Proto_err}, 16'd0);

        // Reset after the first WE-low cycle discards the write
        init_wr(10'h050, 16'h5050);
        Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 20'h00050; Data_to_SRAM = 16'h9999;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        idle();
        check("rst_wr_rd_valid", {15'd0, Rd_valid}, 16'd0);
        check("rst_wr_wr_done", {15'd0, Wr_done}, 16'd0);
        check("rst_wr_proto", {15'd0, Proto_err}, 16'd0);
        check("rst_wr_data", Data_from_SRAM, 16'h0000);
        tick();
        bus_read(20'h00050, 1'b0, 1'b0, 2, 16'h5050);

        // Both lanes disabled on a write: error, word unchanged
        init_wr(10'h060, 16'h6060);
        bus_write(20'h00060, 16'h0BAD, 1'b1, 1'b1, 1'b1, 2);
        check("no_lane_proto", {15'd0, Proto_err}, 16'd1);
        bus_read(20'h00060, 1'b0, 1'b0, 2, 16'h6060);

        tick();
        tick();
        check("queue_drained", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
